// File: rtl/mmu_pkg.sv
// Shared MMU types: exception classes, arbiter states, requester identity, field widths.
// Used by tlb_lookup_arbiter and mmu_utlb_entry.
package mmu_pkg;

  localparam int unsigned VPN_W = 20;
  localparam int unsigned PFN_W = 20;
  localparam int unsigned OFS_W = 12;
  localparam logic [2:0]  UNCACHED = 3'd2;

  typedef enum logic [1:0] {
    ExcNone     = 2'd0,
    ExcRefill   = 2'd1,
    ExcInvalid  = 2'd2,
    ExcModified = 2'd3
  } mmu_exc_e;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} mmu_arb_state_e;

  typedef enum logic {OwnerInst = 1'b0, OwnerData = 1'b1} mmu_owner_e;

  // MIPS TLB exception priority: refill, then invalid, then modified (stores only).
  function automatic mmu_exc_e tlb_exc_class(logic hit, logic v, logic d, logic store);
    if (!hit) return ExcRefill;
    if (!v) return ExcInvalid;
    if (store && !d) return ExcModified;
    return ExcNone;
  endfunction

endpackage

// File: rtl/mmu_utlb_entry.sv
// One-entry micro-TLB: caches the last valid translation for one requester.
// Flush has priority over a coincident fill.
module mmu_utlb_entry
  import mmu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fill,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PFN_W-1:0] fill_pfn,
  input  logic             fill_v,
  input  logic             fill_d,
  input  logic [2:0]       fill_c,
  input  logic [VPN_W-1:0] lookup_vpn,
  input  logic             lookup_store,
  output logic             hit,
  output logic [PFN_W-1:0] pfn,
  output logic [2:0]       c
);

  logic             valid_q;
  logic             v_q;
  logic             d_q;
  logic [VPN_W-1:0] vpn_q;
  logic [PFN_W-1:0] pfn_q;
  logic [2:0]       c_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      v_q     <= 1'b0;
      d_q     <= 1'b0;
      vpn_q   <= '0;
      pfn_q   <= '0;
      c_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      v_q     <= fill_v;
      d_q     <= fill_d;
      vpn_q   <= fill_vpn;
      pfn_q   <= fill_pfn;
      c_q     <= fill_c;
    end
  end

  // A clean entry cannot satisfy a store; that must go to the TLB to raise MODIFIED.
  assign hit = valid_q & v_q & (vpn_q == lookup_vpn) & (~lookup_store | d_q);
  assign pfn = pfn_q;
  assign c   = c_q;

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Round-robin arbiter sharing one TLB lookup port between inst-fetch and data translation.
// Define TLB_LOOKUP_UTLB_EN to add a one-entry micro-TLB per requester.
module tlb_lookup_arbiter
  import mmu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             i_req_ready,
  input  logic [31:0]      i_vaddr,
  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic [31:0]      d_vaddr,
  input  logic             d_is_store,
  output logic             i_resp_valid,
  output logic [31:0]      i_paddr,
  output logic [1:0]       i_exc,
  output logic             i_cached,
  output logic             d_resp_valid,
  output logic [31:0]      d_paddr,
  output logic [1:0]       d_exc,
  output logic             d_cached,
  output logic             tlb_req_valid,
  input  logic             tlb_req_ready,
  output logic [VPN_W-1:0] tlb_vpn,
  input  logic             tlb_resp_valid,
  input  logic             tlb_hit,
  input  logic             tlb_v,
  input  logic             tlb_d,
  input  logic [PFN_W-1:0] tlb_pfn,
  input  logic [2:0]       tlb_c,
  input  logic             tlb_flush
);

  mmu_arb_state_e   state_q;
  mmu_owner_e       owner_q, last_grant_q, acc_owner, res_owner;
  logic [31:0]      vaddr_q, acc_vaddr, res_paddr;
  logic             store_q, acc_store, grant_data, idle, accept;
  logic             res_load, res_cached;
  mmu_exc_e         res_exc;
  logic             utlb_hit;
  logic [PFN_W-1:0] utlb_pfn;
  logic [2:0]       utlb_c;

  assign idle = (state_q == StIdle);
  // Data wins unless inst is also valid and data won last time.
  assign grant_data    = d_req_valid & (~i_req_valid | (last_grant_q == OwnerInst));
  assign i_req_ready   = rst & idle & ~grant_data;
  assign d_req_ready   = rst & idle & grant_data;
  assign accept        = (i_req_valid & i_req_ready) | (d_req_valid & d_req_ready);
  assign acc_owner     = grant_data ? OwnerData : OwnerInst;
  assign acc_vaddr     = grant_data ? d_vaddr : i_vaddr;
  assign acc_store     = grant_data & d_is_store;
  assign tlb_req_valid = (state_q == StIssue);
  assign tlb_vpn       = vaddr_q[31:OFS_W];

`ifdef TLB_LOOKUP_UTLB_EN
  logic             fill, i_hit, d_hit;
  logic [PFN_W-1:0] i_pfn_e, d_pfn_e;
  logic [2:0]       i_c_e, d_c_e;

  assign fill = (state_q == StWait) & tlb_resp_valid & tlb_hit & tlb_v;

  mmu_utlb_entry u_i_utlb (
    .clk          (clk),
    .rst          (rst),
    .flush        (tlb_flush),
    .fill         (fill & (owner_q == OwnerInst)),
    .fill_vpn     (vaddr_q[31:OFS_W]),
    .fill_pfn     (tlb_pfn),
    .fill_v       (tlb_v),
    .fill_d       (tlb_d),
    .fill_c       (tlb_c),
    .lookup_vpn   (i_vaddr[31:OFS_W]),
    .lookup_store (1'b0),
    .hit          (i_hit),
    .pfn          (i_pfn_e),
    .c            (i_c_e)
  );

  mmu_utlb_entry u_d_utlb (
    .clk          (clk),
    .rst          (rst),
    .flush        (tlb_flush),
    .fill         (fill & (owner_q == OwnerData)),
    .fill_vpn     (vaddr_q[31:OFS_W]),
    .fill_pfn     (tlb_pfn),
    .fill_v       (tlb_v),
    .fill_d       (tlb_d),
    .fill_c       (tlb_c),
    .lookup_vpn   (d_vaddr[31:OFS_W]),
    .lookup_store (d_is_store),
    .hit          (d_hit),
    .pfn          (d_pfn_e),
    .c            (d_c_e)
  );

  assign utlb_hit = grant_data ? d_hit : i_hit;
  assign utlb_pfn = grant_data ? d_pfn_e : i_pfn_e;
  assign utlb_c   = grant_data ? d_c_e : i_c_e;
`else
  logic unused_flush;
  assign unused_flush = tlb_flush;
  assign utlb_hit = 1'b0;
  assign utlb_pfn = '0;
  assign utlb_c   = '0;
`endif

  // Result source: micro-TLB hit at accept time, or the shared TLB response in WAIT.
  always_comb begin
    res_load   = 1'b0;
    res_owner  = owner_q;
    res_exc    = ExcNone;
    res_paddr  = '0;
    res_cached = 1'b0;
    if (idle) begin
      res_load   = accept & utlb_hit;
      res_owner  = acc_owner;
      res_paddr  = {utlb_pfn, acc_vaddr[OFS_W-1:0]};
      res_cached = (utlb_c != UNCACHED);
    end else if (state_q == StWait) begin
      res_load = tlb_resp_valid;
      res_exc  = tlb_exc_class(tlb_hit, tlb_v, tlb_d, store_q);
      if (res_exc == ExcNone) begin
        res_paddr  = {tlb_pfn, vaddr_q[OFS_W-1:0]};
        res_cached = (tlb_c != UNCACHED);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnerInst;
      last_grant_q <= OwnerInst;
      vaddr_q      <= '0;
      store_q      <= 1'b0;
      i_resp_valid <= 1'b0;
      i_paddr      <= '0;
      i_exc        <= ExcNone;
      i_cached     <= 1'b0;
      d_resp_valid <= 1'b0;
      d_paddr      <= '0;
      d_exc        <= ExcNone;
      d_cached     <= 1'b0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if (res_load) begin
        if (res_owner == OwnerInst) begin
          i_resp_valid <= 1'b1;
          i_paddr      <= res_paddr;
          i_exc        <= res_exc;
          i_cached     <= res_cached;
        end else begin
          d_resp_valid <= 1'b1;
          d_paddr      <= res_paddr;
          d_exc        <= res_exc;
          d_cached     <= res_cached;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q <= acc_owner;
            vaddr_q <= acc_vaddr;
            store_q <= acc_store;
            state_q <= utlb_hit ? StResp : StIssue;
          end
        end
        StIssue: if (tlb_req_ready) state_q <= StWait;
        StWait:  if (tlb_resp_valid) state_q <= StResp;
        StResp: begin
          last_grant_q <= owner_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/tlb_lookup_arbiter.md
# tlb_lookup_arbiter

Shares the single TLB lookup port between the instruction-fetch and data-access translation paths, for addresses the segment mapper flags as TLB-mapped (kuseg/kseg2/kseg3). It accepts one request at a time from either requester using a round-robin valid/ready handshake, and drives the shared TLB port with a request/response handshake. It returns the physical address and MIPS TLB exception class (refill/invalid/modified) to the granted requester. It sits between the per-path segment mappers and the TLB array inside the MMU.

## Interface
- No parameters; widths fixed at VA/PA = 32, VPN = 20, PFN = 20, page offset = 12.
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- i_req_valid  in  1  instruction translation request
- i_req_ready  out  1  instruction request accepted when valid & ready
- i_vaddr  in  32  instruction virtual address
- d_req_valid  in  1  data translation request
- d_req_ready  out  1  data request accepted when valid & ready
- d_vaddr  in  32  data virtual address
- d_is_store  in  1  data request is a store
- i_resp_valid / d_resp_valid  out  1  one-cycle result pulse; no backpressure
- i_paddr / d_paddr  out  32  {pfn, vaddr[11:0]}; 0 when exception ≠ NONE
- i_exc / d_exc  out  2  mmu_exc_e: NONE=0, REFILL=1, INVALID=2, MODIFIED=3
- i_cached / d_cached  out  1  1 when TLB C field ≠ 3'd2
- tlb_req_valid  out  1  lookup request; held until tlb_req_ready
- tlb_req_ready  in  1  TLB accepts lookup
- tlb_vpn  out  20  VPN of the granted request; stable while tlb_req_valid
- tlb_resp_valid  in  1  lookup result valid, ≥1 cycle after acceptance
- tlb_hit, tlb_v, tlb_d  in  1  match, valid bit, dirty bit
- tlb_pfn  in  20  matched PFN
- tlb_c  in  3  cache attribute
- tlb_flush  in  1  TLB written (TLBWI/TLBWR) or ASID changed

## Operation
- FSM mmu_arb_state_e: IDLE, ISSUE, WAIT, RESP.
- IDLE: ready = 1 for the requester chosen by the arbiter, 0 for the other. If both are valid, grant the one that did not win last time (last_grant flop; reset value = INST, so data wins the first tie). If one is valid, it wins. On acceptance, latch vaddr, is_store and owner, then go to ISSUE.
- ISSUE: tlb_req_valid = 1. On tlb_req_ready, go to WAIT.
- WAIT: on tlb_resp_valid, latch the result, then go to RESP.
- RESP: pulse the owner's resp_valid for exactly one cycle, update last_grant, then go to IDLE.
- Exception priority: !hit → REFILL; hit & !v → INVALID; hit & v & store & !d → MODIFIED; otherwise NONE. Stores are data-only; inst is_store = 0.
- Both ready outputs are 0 outside IDLE. Only one request is in flight at a time.
- tlb_flush affects only the configurable cache (below). An in-flight lookup completes and is delivered.
- Reset mid-operation: FSM returns to IDLE, in-flight result is dropped, no resp pulse is produced.
- A tlb_resp_valid outside WAIT is ignored.

## Timing
- Reset values: all ready = 0 during reset; tlb_req_valid = 0, every resp_valid = 0, paddr = 0, exc = NONE, cached = 0, tlb_vpn = 0.
- After reset release, ready is asserted from the first clock (IDLE).
- Accept at cycle N → tlb_req_valid at N+1. With tlb_req_ready = 1 and tlb_resp_valid at N+2, resp_valid is at N+3. Minimum miss latency is 3 cycles.
- resp data outputs are registered and hold their value until the next RESP.
- Back-to-back accepts from the same requester are at least 4 cycles apart.

## Configuration
- TLB_LOOKUP_UTLB_EN defined: each requester gets a one-entry micro-TLB holding {valid, vpn, pfn, v, d, c}.
  - In IDLE, an accepted request whose VPN matches a valid entry with v = 1 (and, for stores, d = 1) goes straight to RESP. Hit latency is 1 cycle and the shared port is untouched.
  - Every hit & v result from the TLB fills the owner's entry.
  - tlb_flush clears both valid bits in the same cycle. A fill coinciding with flush is suppressed.
- TLB_LOOKUP_UTLB_EN undefined: no micro-TLB; every request goes through ISSUE/WAIT.

## Structure
- mmu_pkg contains: mmu_exc_e, mmu_arb_state_e, the owner enum (INST/DATA), the width localparams (VPN_W = 20, PFN_W = 20, OFS_W = 12), and the C-field value UNCACHED = 3'd2.
- Sub-module mmu_utlb_entry (lookup, fill, flush, async reset) is instantiated twice only under TLB_LOOKUP_UTLB_EN.

## Test plan
- Inst only, vaddr 0x0040_1234; TLB responds 1 cycle after ready with hit = 1, v = 1, pfn = 0x1F000, c = 3 → i_resp_valid 3 cycles after accept; i_paddr = 0x1F00_0234, exc NONE, cached = 1.
- Both valid every cycle → grants alternate D, I, D, I starting with DATA; no requester is granted twice in a row.
- Data store vaddr 0x7FFF_F000 with hit = 1, v = 1, d = 0 → d_exc MODIFIED, d_paddr 0. With hit = 0 → REFILL. With hit = 1, v = 0 → INVALID.
- tlb_req_ready held low 5 cycles → tlb_req_valid and tlb_vpn stay stable; response follows the ready cycle.
- rst asserted during WAIT → no resp_valid pulse; after release a fresh request completes normally.
- UTLB_EN: repeat the same inst VPN → second response 1 cycle after accept with no tlb_req_valid. Pulse tlb_flush, then repeat → full 3-cycle lookup.
